// File: rtl/enc64x6_rr_queue.sv
// rtl/enc64x6_rr_queue.sv - 64-line request collector with round-robin 6-bit index encoder and registered valid/ready output
module enc64x6_rr_queue #(
    parameter int N_REQ = 64,
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_in,
    input  logic                 clr_all,
    output logic [IDX_W-1:0]     idx_out,
    output logic                 idx_valid,
    input  logic                 idx_ready,
    output logic [IDX_W:0]       pend_cnt,
    output logic                 pend_any
);

    logic [N_REQ-1:0] pending;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             slot_free;
    logic             load;
    logic [N_REQ-1:0] claim_mask;

    // Scan upward from ptr with natural 6-bit wrap; first hit wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_cnt = pend_cnt + {{IDX_W{1'b0}}, pending[i]};
        end
    end

    assign pend_any   = |pending;
    assign slot_free  = !idx_valid || idx_ready;
    assign load       = slot_free && found;
    assign claim_mask = load ? (N_REQ'(1) << sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ptr       <= '0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
        end else if (clr_all) begin
            pending   <= '0;
            ptr       <= '0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
        end else begin
            // OR after the clear so a re-request of the claimed bit keeps it pending.
            pending <= (pending & ~claim_mask) | req_in;
            if (slot_free) begin
                if (found) begin
                    idx_out   <= sel;
                    idx_valid <= 1'b1;
                    ptr       <= sel + 1'b1;
                end else begin
                    idx_valid <= 1'b0;
                end
            end
        end
    end

endmodule
